// File: rtl/prog_loader_pkg.sv
// Shared processor defines: instruction memory geometry and loader state encoding.
package prog_loader_pkg;
  localparam int IMEM_DEPTH = 32;
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } ld_state_t;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler: 2-bit byte counter plus a 32-bit right-shift register.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift_en) begin
      cnt  <= cnt + 2'd1;
      // first byte ends up in [7:0] after four shifts
      word <= {byte_data, word[31:8]};
    end
  end

  // high on the transfer that delivers the fourth byte of a word
  assign word_ready = shift_en && (cnt == 2'd3);
endmodule

// File: rtl/prog_loader.sv
// Host byte-stream program loader: count byte, then N little-endian words into imem; holds the datapath in reset until done.
module prog_loader #(
  parameter int IMEM_DEPTH = prog_loader_pkg::IMEM_DEPTH,
  parameter int ADDR_W     = prog_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
  import prog_loader_pkg::*;

  ld_state_t         state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   idx_nxt;
  logic [31:0]       pk_word;
  logic              pk_ready;
  logic              xfer;
  logic              len_ok;

  assign xfer    = byte_valid && byte_ready;
  assign len_ok  = (int'(byte_data) >= 1) && (int'(byte_data) <= IMEM_DEPTH);
  assign idx_nxt = {1'b0, idx} + (ADDR_W+1)'(1);

  byte_packer u_pk (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == LEN),
    .shift_en   (xfer && (state == DATA)),
    .byte_data  (byte_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_words    <= '0;
      idx        <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          state      <= LEN;
          byte_ready <= 1'b1;
        end
        LEN: if (xfer) begin
          n_words <= (ADDR_W+1)'(byte_data);
          idx     <= '0;
          if (len_ok) begin
            state <= DATA;
          end else begin
            state      <= ERR;
            byte_ready <= 1'b0;
            error      <= 1'b1;
          end
        end
        DATA: if (pk_ready) begin
          // capture the completed word straight from the last byte so the write is registered
          state      <= WRITE;
          byte_ready <= 1'b0;
          imem_we    <= 1'b1;
          imem_addr  <= idx;
          imem_wdata <= {byte_data, pk_word[31:8]};
        end
        WRITE: begin
          if (idx_nxt < n_words) begin
            idx        <= idx_nxt[ADDR_W-1:0];
            state      <= DATA;
            byte_ready <= 1'b1;
          end else begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected imem writes queued at stimulus time, checked on each imem_we.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int DEPTH = IMEM_DEPTH;

  logic          clk;
  logic          reset;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  prog_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_cmp;
  int          n_bad;
  int          we_cnt;
  int          we0;
  logic [31:0] mem  [DEPTH];
  logic [31:0] prog [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // write monitor: every imem_we must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && imem_we) begin
        we_cnt++;
        mem[imem_addr] = imem_wdata;
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          chk("wr_data", imem_wdata, mon_e.data);
        end
      end
    end
  end

  // called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = $urandom_range(255, 0);
  endtask

  task automatic load(input int n, input bit stall);
    logic [31:0] w;
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      exp_q.push_back('{addr: AW'(i), data: w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        if (k == 3) chk("we_latency", 32'(imem_we), 32'd1);
        if (stall) repeat ($urandom_range(2, 0)) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(done), 32'd1);
    chk("cpu_reset_run", 32'(cpu_reset), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},    32'(imem_we),    32'd0);
    chk({tag, "_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_cpurst"},32'(cpu_reset),  32'd1);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_error"}, 32'(error),      32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; we_cnt = 0;
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("cpu_reset_loading", 32'(cpu_reset), 32'd1);

    // N=5 nominal program
    prog[0] = 32'h00221820; prog[1] = 32'h8C010004; prog[2] = 32'h00430820;
    prog[3] = 32'hAC020008; prog[4] = 32'h1022FFFF;
    we0 = we_cnt;
    load(5, 1'b0);
    wait_done();
    chk("we_count_n5", 32'(we_cnt - we0), 32'd5);
    chk("q_empty_n5", 32'(exp_q.size()), 32'd0);
    // RUN ignores the host
    byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("run_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    chk("run_no_we", 32'(we_cnt - we0), 32'd5);

    // out-of-range count bytes
    for (int j = 0; j < 2; j++) begin
      do_reset();
      we0 = we_cnt;
      send_byte((j == 0) ? 8'h00 : 8'h21);
      repeat (2) @(negedge clk);
      chk("err_flag", 32'(error), 32'd1);
      chk("err_cpurst", 32'(cpu_reset), 32'd1);
      chk("err_ready", 32'(byte_ready), 32'd0);
      chk("err_done", 32'(done), 32'd0);
      chk("err_no_we", 32'(we_cnt - we0), 32'd0);
    end

    // N=2 with randomly stalled byte_valid
    do_reset();
    prog[0] = $urandom; prog[1] = $urandom;
    mem[0] = 32'h0; mem[1] = 32'h0;
    we0 = we_cnt;
    load(2, 1'b1);
    wait_done();
    chk("we_count_stall", 32'(we_cnt - we0), 32'd2);
    chk("mem0_stall", mem[0], prog[0]);
    chk("mem1_stall", mem[1], prog[1]);

    // reset after 2nd byte of word 1
    do_reset();
    prog[0] = 32'hDEADBEEF; prog[1] = 32'h12345678;
    send_byte(8'd2);
    exp_q.push_back('{addr: AW'(0), data: prog[0]});
    for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8]);
    send_byte(prog[1][7:0]);
    send_byte(prog[1][15:8]);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("q_empty_midrst", 32'(exp_q.size()), 32'd0);
    prog[0] = 32'hCAFEF00D;
    we0 = we_cnt;
    load(1, 1'b0);
    wait_done();
    chk("we_count_n1", 32'(we_cnt - we0), 32'd1);
    chk("mem0_n1", mem[0], 32'hCAFEF00D);

    // full-depth load
    do_reset();
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    we0 = we_cnt;
    load(DEPTH, 1'b0);
    wait_done();
    chk("we_count_full", 32'(we_cnt - we0), 32'(DEPTH));
    chk("last_addr_full", 32'(imem_addr), 32'(DEPTH - 1));
    chk("mem_last_full", mem[DEPTH-1], prog[DEPTH-1]);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      chk("full_extra_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    chk("full_no_extra_we", 32'(we_cnt - we0), 32'(DEPTH));
    chk("q_empty_end", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
